dnn_out_argmax: RTL and testbench
=================================

Name: dnn_out_argmax

Overview:
Parametrised output stage for the inference engine. Snapshots the NUM_CLASSES signed fixed-point scores when the engine signals done. Serially scans the snapshot for the winning class, which is the recognised digit. Provides registered indexed readout of any snapshot score to the test harness and top level.

Parameters:
DATA_WIDTH, 15, signed fixed-point score width (matches engine output).
NUM_CLASSES, 10, number of output neurons/scores; legal range 2..16.
IDX_WIDTH, 4, width of class indices; must satisfy 2**IDX_WIDTH >= NUM_CLASSES.

Ports:
clk  input  1  single system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
nn_done  input  1  engine done level; its 0->1 transition triggers capture.
scores  input  NUM_CLASSES*DATA_WIDTH  packed signed scores; class k at bits [k*DATA_WIDTH +: DATA_WIDTH].
clear  input  1  synchronous soft clear of the result state; snapshot is kept.
out_idx  input  IDX_WIDTH  unsigned readout index.
out  output  DATA_WIDTH  signed snapshot score selected by out_idx, registered.
out_idx_err  output  1  registered; high when the sampled out_idx >= NUM_CLASSES.
busy  output  1  high while state is SCAN.
argmax_valid  output  1  level; high in DONE.
argmax_pulse  output  1  one-cycle pulse on entry to DONE.
argmax_idx  output  IDX_WIDTH  winning class index.
argmax_val  output  DATA_WIDTH  winning score.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; snapshot all zeros; done_q=0.
  - out=0, out_idx_err=0, busy=0, argmax_valid=0, argmax_pulse=0, argmax_idx=0, argmax_val=0.
  - rst has priority over every other input.
- Edge detect: done_q registers nn_done. Capture condition is nn_done=1 && done_q=0. A held-high nn_done does not re-trigger.
- Capture (any state, including SCAN and DONE):
  - snapshot <= scores.
  - best_idx <= 0, best_val <= scores[class 0], ptr <= 1.
  - argmax_valid <= 0, state <= SCAN.
  - A capture during SCAN aborts that scan and restarts on the new data.
- SCAN: one compare per cycle on snapshot[ptr].
  - If snapshot[ptr] > best_val (signed, strict), update best. Ties keep the lower index.
  - ptr increments each cycle.
  - After comparing ptr = NUM_CLASSES-1: state <= DONE, argmax_idx/argmax_val <= final best, argmax_valid <= 1, argmax_pulse <= 1 for that cycle only.
- Latency: argmax_valid rises NUM_CLASSES-1 clock edges after the capture edge (9 for the default).
- DONE: holds results until the next capture, clear, or rst.
- clear=1:
  - state <= IDLE; argmax_valid, argmax_pulse, argmax_idx, argmax_val, busy cleared.
  - Snapshot and readout are unaffected.
  - If clear and a capture occur in the same cycle, the capture wins.
- Readout (independent of FSM state, every cycle):
  - out <= snapshot[out_idx] when out_idx < NUM_CLASSES.
  - Otherwise out <= snapshot[0] and out_idx_err <= 1.
  - One-cycle latency. The snapshot is written at the same edge it is read, so a read at the capture edge returns the old snapshot.
- busy = (state == SCAN).
- No arithmetic beyond signed comparison; no saturation needed.

Test Plan:
- Reset then idle: rst high 2 cycles, release -> all outputs 0, busy=0, argmax_valid=0; out_idx=3 gives out=0 next cycle.
- Basic argmax: scores {0:-5,1:100,2:30,3:0,4:7,5:-100,6:99,7:1,8:2,9:3}, nn_done 0->1 and held -> busy high 9 cycles, then argmax_valid=1, argmax_pulse one cycle, argmax_idx=1, argmax_val=100; no second pulse while nn_done stays high.
- Tie and all negative: all scores = -16384 except classes 4 and 7 = -1 -> argmax_idx=4, argmax_val=-1.
- Readout and error: after capture, out_idx sweeps 0..15 -> out equals snapshot[k] one cycle later for k<=9; for k=10..15, out=snapshot[0] and out_idx_err=1.
- Restart mid-scan: capture set A, then 4 cycles later drop nn_done and raise it again with set B (winner class 9 = 500) -> result reflects B only: argmax_idx=9, argmax_val=500; valid rises 9 edges after the second capture.
- Clear/rst collisions: in DONE, assert clear -> argmax_valid=0, argmax_idx=0, readout still returns the old snapshot. Assert rst during SCAN -> IDLE and all outputs 0 next cycle. clear together with a nn_done rise -> capture proceeds, busy=1.

Source files
------------

// File: rtl/dnn_out_argmax.sv
// Output stage of the inference engine: snapshots the class scores on the rising
// edge of nn_done, serially scans them for the winning class, and gives indexed readout.
module dnn_out_argmax #(
  parameter int DATA_WIDTH  = 15,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               nn_done,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0]  scores,
  input  logic                               clear,
  input  logic [IDX_WIDTH-1:0]               out_idx,
  output logic signed [DATA_WIDTH-1:0]       out,
  output logic                               out_idx_err,
  output logic                               busy,
  output logic                               argmax_valid,
  output logic                               argmax_pulse,
  output logic [IDX_WIDTH-1:0]               argmax_idx,
  output logic signed [DATA_WIDTH-1:0]       argmax_val
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic [IDX_WIDTH:0]   NCLS = (IDX_WIDTH + 1)'(NUM_CLASSES);

  state_t                                   r_state;
  logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0]   r_snap;
  logic                                     r_done_q;
  logic [IDX_WIDTH-1:0]                     r_ptr;
  logic [IDX_WIDTH-1:0]                     r_best_idx;
  logic signed [DATA_WIDTH-1:0]             r_best_val;

  logic                                     w_capture;
  logic signed [DATA_WIDTH-1:0]             w_cand;
  logic                                     w_gt;
  logic [IDX_WIDTH-1:0]                     w_nxt_idx;
  logic signed [DATA_WIDTH-1:0]             w_nxt_val;
  logic                                     w_rd_ok;
  logic [IDX_WIDTH-1:0]                     w_rd_sel;

  assign w_capture = nn_done & ~r_done_q;

  // Strict greater-than so ties keep the earlier (lower) class index.
  assign w_cand    = $signed(r_snap[r_ptr]);
  assign w_gt      = w_cand > r_best_val;
  assign w_nxt_idx = w_gt ? r_ptr  : r_best_idx;
  assign w_nxt_val = w_gt ? w_cand : r_best_val;

  assign w_rd_ok   = {1'b0, out_idx} < NCLS;
  assign w_rd_sel  = w_rd_ok ? out_idx : '0;

  assign busy = (r_state == SCAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_snap       <= '0;
      r_done_q     <= 1'b0;
      r_ptr        <= '0;
      r_best_idx   <= '0;
      r_best_val   <= '0;
      out          <= '0;
      out_idx_err  <= 1'b0;
      argmax_valid <= 1'b0;
      argmax_pulse <= 1'b0;
      argmax_idx   <= '0;
      argmax_val   <= '0;
    end else begin
      r_done_q     <= nn_done;
      argmax_pulse <= 1'b0;
      // Readout sees the pre-capture snapshot at the capture edge.
      out          <= r_snap[w_rd_sel];
      out_idx_err  <= ~w_rd_ok;

      if (w_capture) begin
        r_snap       <= scores;
        r_best_idx   <= '0;
        r_best_val   <= scores[DATA_WIDTH-1:0];
        r_ptr        <= IDX_WIDTH'(1);
        argmax_valid <= 1'b0;
        r_state      <= SCAN;
      end else if (clear) begin
        r_state      <= IDLE;
        argmax_valid <= 1'b0;
        argmax_idx   <= '0;
        argmax_val   <= '0;
      end else if (r_state == SCAN) begin
        r_best_idx <= w_nxt_idx;
        r_best_val <= w_nxt_val;
        r_ptr      <= r_ptr + 1'b1;
        if (r_ptr == LAST) begin
          r_state      <= DONE;
          argmax_idx   <= w_nxt_idx;
          argmax_val   <= w_nxt_val;
          argmax_valid <= 1'b1;
          argmax_pulse <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dnn_out_argmax.sv
// Bench for dnn_out_argmax: directed table, random vectors vs. a max-then-first-index
// reference, plus hand sequences for readout, restart, clear and reset collisions.
module tb_dnn_out_argmax;
  localparam int DW = 15;
  localparam int NC = 10;
  localparam int IW = 4;

  typedef logic [NC-1:0][DW-1:0] vec_s_t;
  typedef struct packed {
    vec_s_t               s;
    logic [IW-1:0]        idx;
    logic signed [DW-1:0] val;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst, nn_done, clear;
  logic [NC*DW-1:0]     scores;
  logic [IW-1:0]        out_idx;
  logic signed [DW-1:0] out, argmax_val;
  logic                 out_idx_err, busy, argmax_valid, argmax_pulse;
  logic [IW-1:0]        argmax_idx;

  int n_cmp = 0;
  int n_err = 0;
  vec_s_t snap_m;
  vec_t   tbl [5];
  int     a1 [NC] = '{-5, 100, 30, 0, 7, -100, 99, 1, 2, 3};

  dnn_out_argmax #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .nn_done(nn_done), .scores(scores), .clear(clear),
    .out_idx(out_idx), .out(out), .out_idx_err(out_idx_err), .busy(busy),
    .argmax_valid(argmax_valid), .argmax_pulse(argmax_pulse),
    .argmax_idx(argmax_idx), .argmax_val(argmax_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: find the maximum value, then the first class holding it.
  function automatic void ref_argmax(input vec_s_t s, output int idx, output int val);
    int mx;
    mx = int'($signed(s[0]));
    for (int k = 1; k < NC; k++)
      if (int'($signed(s[k])) > mx) mx = int'($signed(s[k]));
    idx = -1;
    for (int k = NC - 1; k >= 0; k--)
      if (int'($signed(s[k])) == mx) idx = k;
    val = mx;
  endfunction

  task automatic check_zero_outs(input string tag);
    chk({tag, ".out"}, int'(out), 0);
    chk({tag, ".err"}, int'(out_idx_err), 0);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".valid"}, int'(argmax_valid), 0);
    chk({tag, ".pulse"}, int'(argmax_pulse), 0);
    chk({tag, ".idx"}, int'(argmax_idx), 0);
    chk({tag, ".val"}, int'(argmax_val), 0);
  endtask

  // After the capture edge: busy for NC-1 cycles, then valid + single pulse.
  task automatic wait_result(input int eidx, input int eval, input string tag);
    int cnt;
    cnt = 0;
    while (!argmax_valid && cnt < 40) begin
      chk({tag, ".busy"}, int'(busy), 1);
      tick;
      cnt++;
    end
    chk({tag, ".latency"}, cnt, NC - 1);
    chk({tag, ".busy_done"}, int'(busy), 0);
    chk({tag, ".pulse"}, int'(argmax_pulse), 1);
    chk({tag, ".idx"}, int'(argmax_idx), eidx);
    chk({tag, ".val"}, int'(argmax_val), eval);
    tick;
    chk({tag, ".pulse_off"}, int'(argmax_pulse), 0);
    chk({tag, ".valid_hold"}, int'(argmax_valid), 1);
    tick;
    chk({tag, ".no_retrig"}, int'(busy), 0);
  endtask

  task automatic run(input vec_s_t s, input int eidx, input int eval, input string tag);
    nn_done = 1'b0;
    tick;
    scores  = s;
    nn_done = 1'b1;
    tick;
    snap_m  = s;
    wait_result(eidx, eval, tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_s_t s, sa, sb;
    int ridx, rval, v;

    rst = 1'b1; nn_done = 1'b0; clear = 1'b0; scores = '0; out_idx = '0;
    snap_m = '0;

    for (int k = 0; k < NC; k++) tbl[0].s[k] = a1[k][DW-1:0];
    tbl[0].idx = 4'd1;  tbl[0].val = 15'sd100;
    for (int k = 0; k < NC; k++) tbl[1].s[k] = (k == 4 || k == 7) ? 15'h7fff : 15'h4000;
    tbl[1].idx = 4'd4;  tbl[1].val = -15'sd1;
    for (int k = 0; k < NC; k++) tbl[2].s[k] = (k == 9) ? 15'h3fff : 15'h4000;
    tbl[2].idx = 4'd9;  tbl[2].val = 15'sd16383;
    for (int k = 0; k < NC; k++) tbl[3].s[k] = 15'd7;
    tbl[3].idx = 4'd0;  tbl[3].val = 15'sd7;
    for (int k = 0; k < NC; k++) tbl[4].s[k] = (k == 5) ? 15'h4001 : 15'h4000;
    tbl[4].idx = 4'd5;  tbl[4].val = -15'sd16383;

    // Reset then idle
    tick; tick;
    rst = 1'b0;
    tick;
    check_zero_outs("reset");
    out_idx = 4'd3;
    tick;
    chk("reset.readout", int'(out), 0);

    // Directed table
    for (int i = 0; i < 5; i++)
      run(tbl[i].s, int'(tbl[i].idx), int'(tbl[i].val), $sformatf("tbl%0d", i));

    // Readout sweep including out-of-range indices
    run(tbl[0].s, 1, 100, "sweep_cap");
    for (int k = 0; k < 16; k++) begin
      out_idx = IW'(k);
      tick;
      chk($sformatf("rd%0d.out", k), int'(out), int'($signed(snap_m[(k < NC) ? k : 0])));
      chk($sformatf("rd%0d.err", k), int'(out_idx_err), (k >= NC) ? 1 : 0);
    end

    // Restart mid-scan; also a read at the capture edge returns the old snapshot
    sa = tbl[3].s;
    sb = '0;
    sb[9] = 15'd500; sb[3] = 15'd499;
    nn_done = 1'b0; tick;
    scores = sa; nn_done = 1'b1; out_idx = 4'd1;
    tick;
    chk("restart.old_read", int'(out), int'($signed(snap_m[1])));
    snap_m = sa;
    for (int c = 0; c < 3; c++) tick;
    nn_done = 1'b0;
    tick;
    chk("restart.busy_mid", int'(busy), 1);
    scores = sb; nn_done = 1'b1;
    tick;
    chk("restart.old_read2", int'(out), 7);
    snap_m = sb;
    chk("restart.valid_low", int'(argmax_valid), 0);
    wait_result(9, 500, "restart");

    // Clear in DONE keeps snapshot
    clear = 1'b1; tick; clear = 1'b0;
    chk("clear.valid", int'(argmax_valid), 0);
    chk("clear.idx", int'(argmax_idx), 0);
    chk("clear.val", int'(argmax_val), 0);
    chk("clear.busy", int'(busy), 0);
    out_idx = 4'd9;
    tick;
    chk("clear.readout", int'(out), 500);

    // Clear coinciding with a capture: capture wins
    nn_done = 1'b0; tick;
    scores = tbl[0].s; nn_done = 1'b1; clear = 1'b1;
    tick;
    clear = 1'b0;
    snap_m = tbl[0].s;
    chk("clrcap.valid", int'(argmax_valid), 0);
    wait_result(1, 100, "clrcap");

    // Reset during scan
    nn_done = 1'b0; tick;
    scores = tbl[2].s; nn_done = 1'b1;
    tick;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0; nn_done = 1'b0;
    check_zero_outs("rst_scan");
    out_idx = 4'd9;
    tick;
    chk("rst_scan.snap", int'(out), 0);

    // Random vectors against the reference
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < NC; k++) begin
        if (i % 3 == 0) v = int'($urandom_range(0, 6)) - 3;
        else            v = int'($urandom_range(0, 32767)) - 16384;
        s[k] = v[DW-1:0];
      end
      ref_argmax(s, ridx, rval);
      run(s, ridx, rval, $sformatf("rnd%0d", i));
      out_idx = IW'($urandom_range(0, 15));
      tick;
      chk($sformatf("rnd%0d.rd", i), int'(out),
          int'($signed(snap_m[(int'(out_idx) < NC) ? int'(out_idx) : 0])));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
